// File: rtl/alu_fpga_pkg.sv
// Shared types and helpers for the sequenced ALU board harness.
package alu_fpga_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  localparam int KEY_STEP  = 0;
  localparam int KEY_CLEAR = 1;
  localparam int KEY_CHAIN = 2;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] state_led(input state_e st);
    logic [3:0] l;
    case (st)
      S_A:     l = 4'b0001;
      S_B:     l = 4'b0010;
      S_EXEC:  l = 4'b0100;
      default: l = 4'b1000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/alu_fpga_ctrl_if.sv
// Operand/op/result/flag bundle between the harness (master) and the ALU (slave).
interface alu_fpga_ctrl_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] porta;
  logic [DATA_W-1:0] portb;
  logic [3:0]        aluop;
  logic [DATA_W-1:0] portout;
  logic              negative;
  logic              overflow;
  logic              zero;

  modport master (output porta, portb, aluop,
                  input  portout, negative, overflow, zero);
  modport slave  (input  porta, portb, aluop,
                  output portout, negative, overflow, zero);
endinterface

// File: rtl/alu_fpga_ctrl_key_debounce.sv
// Synchronise and debounce one active-low key; one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic nRST,
  input  logic key_n_raw,
  output logic pressed_pulse
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q, stable_q, pulse_q;
  logic [CW-1:0] cnt_q;

  // Down-counter reloads while the level agrees; terminal count accepts the new level.
  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= CNT_TOP;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= CNT_TOP;
      end else if (cnt_q == '0) begin
        stable_q <= sync2_q;
        cnt_q    <= CNT_TOP;
        pulse_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign pressed_pulse = pulse_q;
endmodule

// File: rtl/alu_fpga_ctrl.sv
// Sequenced ALU harness: enter A, enter B, execute, show; result can chain back into A.
//   state  | meaning
//   S_A    | waiting for step to capture operand A from switches
//   S_B    | waiting for step to capture operand B and op code
//   S_EXEC | single cycle; ALU sees new B/op, result and flags latched
//   S_SHOW | result displayed; step -> S_A, chain -> result into A
module alu_fpga_ctrl
  import alu_fpga_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SW_W      = 16,
  parameter int DB_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic                    nRST,
  input  logic [SW_W-1:0]         sw_data,
  input  logic                    sw_sign,
  input  logic [3:0]              sw_op,
  input  logic [2:0]              key_n,
  alu_fpga_ctrl_if.master         alu,
  output logic [DATA_W/4*7-1:0]   hex,
  output logic [2:0]              ledr,
  output logic [3:0]              ledg
);
  localparam int NDIG = DATA_W / 4;

  logic [2:0]        press;
  logic [DATA_W-1:0] ext, disp;
  logic [DATA_W-1:0] reg_a_q, reg_b_q, result_q;
  logic [3:0]        op_q, ledg_q;
  logic [2:0]        flags_q;
  state_e            state_q;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLOCK_50      (CLOCK_50),
      .nRST          (nRST),
      .key_n_raw     (key_n[k]),
      .pressed_pulse (press[k])
    );
  end

  always_comb begin
    ext = {DATA_W{sw_sign}};
    ext[SW_W-1:0] = sw_data;
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      state_q  <= S_A;
      ledg_q   <= state_led(S_A);
    end else if (press[KEY_CLEAR]) begin
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      state_q  <= S_A;
      ledg_q   <= state_led(S_A);
    end else begin
      case (state_q)
        S_A: if (press[KEY_STEP]) begin
          reg_a_q <= ext;
          state_q <= S_B;
          ledg_q  <= state_led(S_B);
        end
        S_B: if (press[KEY_STEP]) begin
          reg_b_q <= ext;
          op_q    <= sw_op;
          state_q <= S_EXEC;
          ledg_q  <= state_led(S_EXEC);
        end
        S_EXEC: begin
          result_q <= alu.portout;
          flags_q  <= {alu.negative, alu.overflow, alu.zero};
          state_q  <= S_SHOW;
          ledg_q   <= state_led(S_SHOW);
        end
        default: if (press[KEY_STEP]) begin
          state_q <= S_A;
          ledg_q  <= state_led(S_A);
        end else if (press[KEY_CHAIN]) begin
          reg_a_q <= result_q;
          state_q <= S_B;
          ledg_q  <= state_led(S_B);
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_EXEC:  disp = reg_b_q;
      S_SHOW:  disp = result_q;
      default: disp = ext;
    endcase
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign hex[7*i +: 7] = seg7(disp[4*i +: 4]);
  end

  assign alu.porta = reg_a_q;
  assign alu.portb = reg_b_q;
  assign alu.aluop = op_q;
  assign ledr      = flags_q;
  assign ledg      = ledg_q;
endmodule

// File: tb/tb_alu_fpga_ctrl.sv
// Bench for alu_fpga_ctrl: vector table, hand sequences for timing corners, randomized walk vs model.
module tb_alu_fpga_ctrl;
  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int DB     = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
  localparam int K_STEP = 0, K_CLEAR = 1, K_CHAIN = 2;
  localparam logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

  logic              CLOCK_50 = 1'b0;
  logic              nRST = 1'b1;
  logic [SW_W-1:0]   sw_data = '0;
  logic              sw_sign = 1'b0;
  logic [3:0]        sw_op = '0;
  logic [2:0]        key_n = 3'b111;
  logic [55:0]       hex;
  logic [2:0]        ledr;
  logic [3:0]        ledg;

  int n_chk = 0;
  int n_pass = 0;

  alu_fpga_ctrl_if #(.DATA_W(DATA_W)) alu ();

  alu_fpga_ctrl #(.DATA_W(DATA_W), .SW_W(SW_W), .DB_CYCLES(DB)) dut (
    .CLOCK_50 (CLOCK_50),
    .nRST     (nRST),
    .sw_data  (sw_data),
    .sw_sign  (sw_sign),
    .sw_op    (sw_op),
    .key_n    (key_n),
    .alu      (alu),
    .hex      (hex),
    .ledr     (ledr),
    .ledg     (ledg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Returns {negative, overflow, zero, result}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    logic ov;
    r = a;
    ov = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = a;
    endcase
    return {r[31], ov, (r == 32'd0), r};
  endfunction

  always_comb {alu.negative, alu.overflow, alu.zero, alu.portout} = alu_ref(alu.porta, alu.portb, alu.aluop);

  function automatic logic [55:0] hex_of(input logic [31:0] v);
    logic [55:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) h[7*i +: 7] = SEG[v[4*i +: 4]];
    return h;
  endfunction

  function automatic logic [31:0] ext_of(input logic [15:0] d, input logic s);
    return {{16{s}}, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic press(input int k);
    @(negedge CLOCK_50);
    key_n[k] = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    key_n[k] = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  typedef struct {
    int          key;
    logic [15:0] data;
    logic        sign;
    logic [3:0]  op;
    logic [3:0]  e_ledg;
    logic [2:0]  e_ledr;
    logic [31:0] e_disp;
    logic [31:0] e_porta;
  } vec_t;

  vec_t tbl [8];

  // Behavioural model: phase 0=A,1=B,3=SHOW (exec is transient between presses)
  int          m_st;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic [2:0]  m_fl;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes;
    logic [3:0] prev;
    tbl[0] = '{K_STEP,  16'h0005, 1'b0, OP_ADD, 4'b0010, 3'b000, 32'h0000_0005, 32'h0000_0005};
    tbl[1] = '{K_STEP,  16'h0003, 1'b0, OP_ADD, 4'b1000, 3'b000, 32'h0000_0008, 32'h0000_0005};
    tbl[2] = '{K_CHAIN, 16'h0002, 1'b0, OP_SUB, 4'b0010, 3'b000, 32'h0000_0002, 32'h0000_0008};
    tbl[3] = '{K_STEP,  16'h0002, 1'b0, OP_SUB, 4'b1000, 3'b000, 32'h0000_0006, 32'h0000_0008};
    tbl[4] = '{K_STEP,  16'hFFFF, 1'b1, OP_ADD, 4'b0001, 3'b000, 32'hFFFF_FFFF, 32'h0000_0008};
    tbl[5] = '{K_STEP,  16'hFFFF, 1'b1, OP_ADD, 4'b0010, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[6] = '{K_STEP,  16'h0001, 1'b0, OP_ADD, 4'b1000, 3'b001, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[7] = '{K_CLEAR, 16'h0000, 1'b0, OP_ADD, 4'b0001, 3'b000, 32'h0000_0000, 32'h0000_0000};

    #5 nRST = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_ledg", ledg, 4'b0001);
    chk("reset_ledr", ledr, 3'b000);
    chk("reset_hex", hex, hex_of(32'd0));
    chk("reset_porta", alu.porta, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    foreach (tbl[i]) begin
      sw_data = tbl[i].data;
      sw_sign = tbl[i].sign;
      sw_op   = tbl[i].op;
      press(tbl[i].key);
      chk($sformatf("vec%0d_ledg", i), ledg, tbl[i].e_ledg);
      chk($sformatf("vec%0d_ledr", i), ledr, tbl[i].e_ledr);
      chk($sformatf("vec%0d_hex", i), hex, hex_of(tbl[i].e_disp));
      chk($sformatf("vec%0d_porta", i), alu.porta, tbl[i].e_porta);
    end

    // Press-to-pulse latency 2+DB, state moves on the following edge
    sw_data = 16'h0011; sw_sign = 1'b0;
    @(negedge CLOCK_50);
    key_n[K_STEP] = 1'b0;
    repeat (2 + DB) @(posedge CLOCK_50);
    #1 chk("lat_a_before", ledg, 4'b0001);
    @(posedge CLOCK_50);
    #1 chk("lat_a_after", ledg, 4'b0010);
    chk("lat_a_porta", alu.porta, 32'h11);
    @(negedge CLOCK_50);
    key_n[K_STEP] = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // B step: exec cycle, then result; late op change must not matter
    sw_data = 16'h0022; sw_op = OP_ADD;
    key_n[K_STEP] = 1'b0;
    repeat (2 + DB) @(posedge CLOCK_50);
    #1 chk("lat_b_before", ledg, 4'b0010);
    @(posedge CLOCK_50);
    #1 chk("exec_ledg", ledg, 4'b0100);
    chk("exec_hex", hex, hex_of(32'h22));
    @(negedge CLOCK_50);
    sw_op = OP_SUB;
    @(posedge CLOCK_50);
    #1 chk("show_ledg", ledg, 4'b1000);
    chk("show_hex", hex, hex_of(32'h33));
    chk("show_aluop", alu.aluop, OP_ADD);
    @(negedge CLOCK_50);
    key_n[K_STEP] = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // Three-cycle glitch is rejected
    key_n[K_STEP] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    key_n[K_STEP] = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    chk("glitch_ledg", ledg, 4'b1000);

    // Ten-cycle hold then release: exactly one transition
    changes = 0;
    prev = ledg;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLOCK_50);
      if (c == 0) key_n[K_STEP] = 1'b0;
      if (c == 10) key_n[K_STEP] = 1'b1;
      @(posedge CLOCK_50);
      #1;
      if (ledg !== prev) changes++;
      prev = ledg;
    end
    chk("hold_changes", changes, 1);
    chk("hold_ledg", ledg, 4'b0001);

    // Clear and step together in S_B
    sw_data = 16'h0007; sw_sign = 1'b0;
    press(K_STEP);
    chk("cs_pre_ledg", ledg, 4'b0010);
    @(negedge CLOCK_50);
    key_n = 3'b100;
    repeat (10) @(negedge CLOCK_50);
    key_n = 3'b111;
    repeat (10) @(negedge CLOCK_50);
    chk("cs_ledg", ledg, 4'b0001);
    chk("cs_porta", alu.porta, 32'd0);
    chk("cs_portb", alu.portb, 32'd0);
    chk("cs_hex", hex, hex_of(32'h7));

    // Reset during S_EXEC
    sw_data = 16'h0009;
    press(K_STEP);
    sw_op = OP_XOR;
    key_n[K_STEP] = 1'b0;
    repeat (3 + DB) @(posedge CLOCK_50);
    #1 chk("rx_exec_ledg", ledg, 4'b0100);
    nRST = 1'b0;
    #1;
    chk("rx_ledg", ledg, 4'b0001);
    chk("rx_porta", alu.porta, 32'd0);
    chk("rx_portb", alu.portb, 32'd0);
    chk("rx_aluop", alu.aluop, 4'd0);
    chk("rx_ledr", ledr, 3'b000);
    key_n = 3'b111;
    @(negedge CLOCK_50);
    nRST = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    chk("rx_after_ledg", ledg, 4'b0001);

    // Randomized walk against the model
    m_st = 0; m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_fl = '0;
    for (int it = 0; it < 30; it++) begin
      int r;
      int k;
      logic [31:0] e, d;
      r = $urandom_range(0, 9);
      k = (r == 0) ? K_CLEAR : (r <= 2) ? K_CHAIN : K_STEP;
      sw_data = 16'($urandom);
      sw_sign = 1'($urandom);
      sw_op   = 4'($urandom_range(0, 7));
      e = ext_of(sw_data, sw_sign);
      press(k);
      if (k == K_CLEAR) begin
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_fl = '0; m_st = 0;
      end else if (k == K_CHAIN) begin
        if (m_st == 3) begin m_a = m_res; m_st = 1; end
      end else begin
        case (m_st)
          0: begin m_a = e; m_st = 1; end
          1: begin m_b = e; m_op = sw_op; {m_fl, m_res} = alu_ref(m_a, m_b, m_op); m_st = 3; end
          default: m_st = 0;
        endcase
      end
      d = (m_st == 3) ? m_res : e;
      chk($sformatf("rnd%0d_ledg", it), ledg, 4'b0001 << m_st);
      chk($sformatf("rnd%0d_ledr", it), ledr, m_fl);
      chk($sformatf("rnd%0d_porta", it), alu.porta, m_a);
      chk($sformatf("rnd%0d_portb", it), alu.portb, m_b);
      chk($sformatf("rnd%0d_aluop", it), alu.aluop, m_op);
      chk($sformatf("rnd%0d_hex", it), hex, hex_of(d));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
